jamma_joy_scheduler: RTL and testbench

- Time-multiplexes the shared JAMMA joystick bus (JJOY) between player 1 and player 2 by driving the external JSELECT line.
- Waits a programmable settle time after every select change, samples one player per phase and debounces each player vector and the coin inputs.
- Presents stable active-low joystick1/joystick2/coin words to the arcade core, replacing the free-running per-clock toggle in the board top level.

---
 rtl/jamma_joy_scheduler.sv | 135 +++++++++++++
 tb/tb_jamma_joy_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jamma_joy_scheduler.sv
// jamma_joy_scheduler
//
// Time-multiplexes the shared JAMMA joystick bus between player 1 and
// player 2. It drives the external select line and waits a settle time after
// each select change. It then samples one player for a single cycle and
// debounces each player word and the coin pair as whole vectors.
//
// Scan order: P1_SETTLE -> P1_SAMPLE -> P2_SETTLE -> P2_SAMPLE -> P1_SETTLE.
// A full scan takes 2*(SETTLE_CYCLES+1) cycles.
//
// Ports:
//   pclk       in   system clock
//   reset      in   synchronous reset, active high
//   enable     in   scan enable; low freezes every register (scan_tick reads 0)
//   jjoy[7:0]  in   raw muxed joystick bus, active low
//   jcoin[1:0] in   raw coin inputs, active low, not muxed
//   local_joy  in   on-board joystick [5:0], active low, merged into player 1
//   jselect    out  external mux select (0 = player 1, 1 = player 2), registered
//   joystick1  out  debounced player 1 word, active low
//   joystick2  out  debounced player 2 word, active low
//   coin       out  debounced coins, active low
//   scan_tick  out  one-cycle pulse in the cycle after P2_SAMPLE
//   state_dbg  out  current scheduler state, for observation only
//
// Handshake: there is no valid/ready pair here. Each sample cycle is the only
// point where bus data is consumed. An output changes only in the cycle after
// a sample whose updated debounce count reaches DEBOUNCE_SCANS.

module jamma_joy_scheduler #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] jjoy,
  input  logic [1:0] jcoin,
  input  logic [5:0] local_joy,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       scan_tick,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] P1_SETTLE = 2'd0;
  localparam logic [1:0] P1_SAMPLE = 2'd1;
  localparam logic [1:0] P2_SETTLE = 2'd2;
  localparam logic [1:0] P2_SAMPLE = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DB_MAX      = 4'(DEBOUNCE_SCANS);

  logic [1:0] state;
  logic [7:0] settle_cnt;

  logic [7:0] p1_cand, p2_cand;
  logic [1:0] coin_cand;
  logic [3:0] p1_cnt, p2_cnt, coin_cnt;

  logic [7:0] p1_sample;
  logic [3:0] p1_next_cnt, p2_next_cnt, coin_next_cnt;

  // The local stick only drives the low six bits of player 1. The top two
  // bits come straight from the bus.
  assign p1_sample = jjoy & {2'b11, local_joy};

  // Count after the update at a sample: it saturates on a repeat and
  // restarts at 1 on any change.
  always_comb begin
    p1_next_cnt   = 4'd1;
    p2_next_cnt   = 4'd1;
    coin_next_cnt = 4'd1;
    if (p1_sample == p1_cand)
      p1_next_cnt = (p1_cnt == DB_MAX) ? DB_MAX : p1_cnt + 4'd1;
    if (jjoy == p2_cand)
      p2_next_cnt = (p2_cnt == DB_MAX) ? DB_MAX : p2_cnt + 4'd1;
    if (jcoin == coin_cand)
      coin_next_cnt = (coin_cnt == DB_MAX) ? DB_MAX : coin_cnt + 4'd1;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= P1_SETTLE;
      settle_cnt <= 8'd0;
      jselect    <= 1'b0;
      joystick1  <= 8'hFF;
      joystick2  <= 8'hFF;
      coin       <= 2'b11;
      scan_tick  <= 1'b0;
      p1_cand    <= 8'hFF;
      p2_cand    <= 8'hFF;
      coin_cand  <= 2'b11;
      p1_cnt     <= 4'd0;
      p2_cnt     <= 4'd0;
      coin_cnt   <= 4'd0;
    end else if (!enable) begin
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= 1'b0;
      case (state)
        P1_SETTLE, P2_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST)
            state <= (state == P1_SETTLE) ? P1_SAMPLE : P2_SAMPLE;
        end
        P1_SAMPLE: begin
          settle_cnt <= 8'd0;
          state      <= P2_SETTLE;
          // Select flips here so it is already valid on the first settle cycle.
          jselect    <= 1'b1;
          p1_cand    <= p1_sample;
          p1_cnt     <= p1_next_cnt;
          if (p1_next_cnt == DB_MAX) joystick1 <= p1_sample;
        end
        default: begin  // P2_SAMPLE
          settle_cnt <= 8'd0;
          state      <= P1_SETTLE;
          jselect    <= 1'b0;
          scan_tick  <= 1'b1;
          p2_cand    <= jjoy;
          p2_cnt     <= p2_next_cnt;
          coin_cand  <= jcoin;
          coin_cnt   <= coin_next_cnt;
          if (p2_next_cnt == DB_MAX)   joystick2 <= jjoy;
          if (coin_next_cnt == DB_MAX) coin      <= jcoin;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_jamma_joy_scheduler.sv
module tb_jamma_joy_scheduler;

  localparam int S  = 8;
  localparam int DB = 3;
  localparam int PERIOD = 2 * (S + 1);

  // clock / reset
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] p1_bus = 8'hFF, p2_bus = 8'hFF;
  logic [1:0] jcoin = 2'b11;
  logic [5:0] local_joy = 6'h3F;
  logic [7:0] jjoy;
  logic       jselect, scan_tick;
  logic [7:0] joystick1, joystick2;
  logic [1:0] coin, state_dbg;

  // Board mux: the external select line chooses which player drives the bus.
  assign jjoy = jselect ? p2_bus : p1_bus;

  jamma_joy_scheduler #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DB)) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .jjoy(jjoy), .jcoin(jcoin),
    .local_joy(local_joy), .jselect(jselect), .joystick1(joystick1),
    .joystick2(joystick2), .coin(coin), .scan_tick(scan_tick),
    .state_dbg(state_dbg)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 30)
        $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: scan position within the period, and per channel the
  // history of the most recent DB samples. An output takes the latest sample
  // once the last DB samples since reset are all identical.
  int         m_pos;
  logic       m_sel, m_tick;
  logic [7:0] m_j1, m_j2;
  logic [1:0] m_coin;
  logic [7:0] hist[3][$];

  function automatic bit db_push(int ch, logic [7:0] s);
    hist[ch].push_back(s);
    if (hist[ch].size() > DB) void'(hist[ch].pop_front());
    if (hist[ch].size() < DB) return 1'b0;
    foreach (hist[ch][i]) if (hist[ch][i] != s) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge pclk) begin
    if (reset) begin
      m_pos = 0; m_sel = 1'b0; m_tick = 1'b0;
      m_j1 = 8'hFF; m_j2 = 8'hFF; m_coin = 2'b11;
      for (int c = 0; c < 3; c++) hist[c].delete();
    end else if (!enable) begin
      m_tick = 1'b0;
    end else begin
      m_tick = (m_pos == PERIOD - 1);
      if (m_pos == S) begin
        logic [7:0] s1;
        s1 = p1_bus & {2'b11, local_joy};
        if (db_push(0, s1)) m_j1 = s1;
      end
      if (m_pos == PERIOD - 1) begin
        if (db_push(1, p2_bus)) m_j2 = p2_bus;
        if (db_push(2, {6'd0, jcoin})) m_coin = jcoin;
      end
      m_pos = (m_pos + 1) % PERIOD;
      m_sel = (m_pos > S);
    end
  end

  // scoreboard: every cycle against the model
  always @(negedge pclk) begin
    if (chk_on) begin
      check("m_jselect",   {7'd0, jselect},   {7'd0, m_sel});
      check("m_scan_tick", {7'd0, scan_tick}, {7'd0, m_tick});
      check("m_joystick1", joystick1, m_j1);
      check("m_joystick2", joystick2, m_j2);
      check("m_coin",      {6'd0, coin}, {6'd0, m_coin});
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge pclk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; p1_bus = 8'hFF; p2_bus = 8'hFF; jcoin = 2'b11; local_joy = 6'h3F;
  endtask

  typedef struct {
    logic [7:0] p1, p2;
    logic [5:0] lj;
    logic [1:0] jc;
    int         at;
    logic [7:0] e1, e2;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 6'h3F, 2'b11, 60, 8'hFF, 8'hFF, 2'b11};
    tbl[1] = '{8'hFE, 8'hFF, 6'h3F, 2'b11, 44, 8'hFF, 8'hFF, 2'b11};
    tbl[2] = '{8'hFE, 8'hFF, 6'h3F, 2'b11, 45, 8'hFE, 8'hFF, 2'b11};
    tbl[3] = '{8'hFF, 8'hFF, 6'h3D, 2'b11, 45, 8'hFD, 8'hFF, 2'b11};
    tbl[4] = '{8'hFF, 8'hFF, 6'h3F, 2'b10, 53, 8'hFF, 8'hFF, 2'b11};
    tbl[5] = '{8'hFF, 8'hFF, 6'h3F, 2'b10, 54, 8'hFF, 8'hFF, 2'b10};
    tbl[6] = '{8'hFF, 8'h7F, 6'h3D, 2'b11, 54, 8'hFD, 8'h7F, 2'b11};
    tbl[7] = '{8'hFF, 8'h7F, 6'h3F, 2'b01, 35, 8'hFF, 8'hFF, 2'b11};

    idle_inputs();
    repeat (3) @(negedge pclk);
    do_reset();
    chk_on = 1'b1;

    // reset state and idle scan timing
    check("rst_state", {6'd0, state_dbg}, 8'd0);
    check("rst_j1", joystick1, 8'hFF);
    check("rst_j2", joystick2, 8'hFF);
    check("rst_coin", {6'd0, coin}, 8'h03);
    for (int c = 0; c <= 2 * PERIOD; c++) begin
      check("idle_jselect", {7'd0, jselect}, {7'd0, ((c % PERIOD) > S)});
      check("idle_tick", {7'd0, scan_tick}, {7'd0, (c > 0 && c % PERIOD == 0)});
      tick();
    end

    // table vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      p1_bus = tbl[i].p1; p2_bus = tbl[i].p2; local_joy = tbl[i].lj; jcoin = tbl[i].jc;
      while (cyc < tbl[i].at) tick();
      check($sformatf("tbl%0d_j1", i), joystick1, tbl[i].e1);
      check($sformatf("tbl%0d_j2", i), joystick2, tbl[i].e2);
      check($sformatf("tbl%0d_coin", i), {6'd0, coin}, {6'd0, tbl[i].ec});
      idle_inputs();
    end

    // P1 samples FE, FE, FF, FE, FE, FE: only the last run of three counts
    do_reset();
    p1_bus = 8'hFE;
    while (cyc < 99) begin
      tick();
      if (cyc == 27) p1_bus = 8'hFF;
      if (cyc == 45) p1_bus = 8'hFE;
      if (cyc == 45) check("brk_j1_45", joystick1, 8'hFF);
      if (cyc == 98) check("brk_j1_98", joystick1, 8'hFF);
    end
    check("brk_j1_99", joystick1, 8'hFE);
    idle_inputs();

    // enable low for 50 cycles in the middle of P2_SETTLE
    do_reset();
    p2_bus = 8'h00;
    while (cyc < 12) tick();
    enable = 1'b0;
    while (cyc < 62) begin
      tick();
      check("frz_jselect", {7'd0, jselect}, 8'd1);
      check("frz_j2", joystick2, 8'hFF);
    end
    enable = 1'b1;
    while (cyc < 67) tick();
    check("frz_tick_67", {7'd0, scan_tick}, 8'd0);
    tick();
    check("frz_tick_68", {7'd0, scan_tick}, 8'd1);
    idle_inputs();

    // reset during P2_SAMPLE discards outputs and the scan position
    do_reset();
    p2_bus = 8'h00; jcoin = 2'b00; p1_bus = 8'h0F;
    while (cyc < 71) tick();
    check("pre_rst_j2", joystick2, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_j1", joystick1, 8'hFF);
    check("mid_rst_j2", joystick2, 8'hFF);
    check("mid_rst_coin", {6'd0, coin}, 8'h03);
    check("mid_rst_jselect", {7'd0, jselect}, 8'd0);
    cyc = 0;
    idle_inputs();

    // randomized traffic, checked against the model every cycle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) p1_bus = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 39) == 0) p2_bus = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 59) == 0) local_joy = 6'($urandom);
      if ($urandom_range(0, 49) == 0) jcoin = 2'($urandom);
      enable = ($urandom_range(0, 15) != 0);
      reset  = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0;
    tick();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
